// File: rtl/debounce_filter.sv
// debounce_filter: input synchronizer plus stability-count debounce feeding the edge detector.
// Define DEBOUNCE_FILTER_EDGE_OUT_EN to add registered rise/fall pulses aligned with q.
module debounce_filter #(
    parameter int unsigned DebounceCount = 8,
    parameter int unsigned CountWidth    = 16,
    parameter int unsigned SyncStages    = 2,
    parameter bit          InitValue     = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    input  logic en,
    output logic q,
    output logic busy
`ifdef DEBOUNCE_FILTER_EDGE_OUT_EN
    ,
    output logic rise,
    output logic fall
`endif
);
    localparam int unsigned Count = (DebounceCount == 0) ? 1 : DebounceCount;
    localparam logic [CountWidth-1:0] CntLast = CountWidth'(Count - 1);

    if (SyncStages < 2 || SyncStages > 3) begin : g_bad_sync
        $error("debounce_filter: SyncStages must be 2 or 3");
    end
    if (Count - 1 >= (64'd1 << CountWidth)) begin : g_bad_width
        $error("debounce_filter: CountWidth too narrow for DebounceCount");
    end

    logic [SyncStages-1:0] sync_q;
    logic [CountWidth-1:0] cnt_q, cnt_d;
    logic                  out_q, out_d;
    logic                  s, done;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) sync_q <= {SyncStages{InitValue}};
        else          sync_q <= {sync_q[SyncStages-2:0], d};
    end

    assign s    = sync_q[SyncStages-1];
    assign done = en && (s != out_q) && (cnt_q == CntLast);

    // counter clears whenever s agrees with q, so a short glitch restarts qualification
    always_comb begin
        cnt_d = !en ? cnt_q : ((s == out_q) || done) ? '0 : cnt_q + 1'b1;
        out_d = done ? s : out_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            out_q <= InitValue;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign q    = out_q;
    assign busy = (cnt_q != '0);

`ifdef DEBOUNCE_FILTER_EDGE_OUT_EN
    logic rise_q, fall_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= done && s;
            fall_q <= done && !s;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`endif
endmodule

// File: tb/tb_debounce_filter.sv
// tb_debounce_filter: directed checks of debounce_filter (defaults, InitValue=1, DebounceCount=1/SyncStages=3).
module tb_debounce_filter;
    logic clock = 1'b0;
    logic rst_n, rst_b_n;
    logic d_a, en_a, q_a, busy_a;
    logic d_b, q_b, busy_b;
    logic d_c, q_c, busy_c;
    logic rise_a, fall_a, rise_b, fall_b, rise_c, fall_c;
    int   checks = 0;
    int   errors = 0;
    logic hist [0:63];
    logic seen;

    always #5 clock = ~clock;

`ifdef DEBOUNCE_FILTER_EDGE_OUT_EN
    debounce_filter u_a (.clock(clock), .reset_n(rst_n), .d(d_a), .en(en_a), .q(q_a), .busy(busy_a),
                         .rise(rise_a), .fall(fall_a));
    debounce_filter #(.InitValue(1'b1)) u_b (.clock(clock), .reset_n(rst_b_n), .d(d_b), .en(1'b1),
                         .q(q_b), .busy(busy_b), .rise(rise_b), .fall(fall_b));
    debounce_filter #(.DebounceCount(1), .SyncStages(3)) u_c (.clock(clock), .reset_n(rst_n), .d(d_c),
                         .en(1'b1), .q(q_c), .busy(busy_c), .rise(rise_c), .fall(fall_c));
`else
    debounce_filter u_a (.clock(clock), .reset_n(rst_n), .d(d_a), .en(en_a), .q(q_a), .busy(busy_a));
    debounce_filter #(.InitValue(1'b1)) u_b (.clock(clock), .reset_n(rst_b_n), .d(d_b), .en(1'b1),
                         .q(q_b), .busy(busy_b));
    debounce_filter #(.DebounceCount(1), .SyncStages(3)) u_c (.clock(clock), .reset_n(rst_n), .d(d_c),
                         .en(1'b1), .q(q_c), .busy(busy_c));
    assign {rise_a, fall_a, rise_b, fall_b, rise_c, fall_c} = '0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; rst_b_n = 1'b0;
        d_a = 1'b0; en_a = 1'b1; d_b = 1'b0; d_c = 1'b0;
        tick();
        check("rst_q_a", q_a, 0);
        check("rst_busy_a", busy_a, 0);
        check("rst_q_b", q_b, 1);
        check("rst_busy_b", busy_b, 0);
        check("rst_rise_fall_a", {rise_a, fall_a}, 0);
        tick();
        rst_n = 1'b1; rst_b_n = 1'b1;
        check("rel_q_b", q_b, 1);
        check("rel_busy_b", busy_b, 0);
        for (int k = 1; k <= 11; k++) begin
            tick();
            check("init_q_b", q_b, k < 10);
`ifdef DEBOUNCE_FILTER_EDGE_OUT_EN
            check("init_fall_b", fall_b, k == 10);
`endif
        end
        // clean rising step
        d_a = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check("step_busy", busy_a, k >= 3 && k <= 9);
            check("step_q", q_a, k >= 10);
`ifdef DEBOUNCE_FILTER_EDGE_OUT_EN
            check("step_rise", rise_a, k == 10);
            check("step_fall", fall_a, 0);
`endif
        end
        d_a = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check("stepdn_q", q_a, k < 10);
`ifdef DEBOUNCE_FILTER_EDGE_OUT_EN
            check("stepdn_fall", fall_a, k == 10);
`endif
        end
        // bounce: high 5, low 2, high 3, low thereafter
        seen = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            d_a = (k <= 5) || (k >= 8 && k <= 10);
            tick();
            seen |= busy_a;
            check("bounce_q", q_a, 0);
            check("bounce_edges", {rise_a, fall_a}, 0);
        end
        check("bounce_busy_seen", seen, 1);
        check("bounce_busy_end", busy_a, 0);
        // enable freeze
        d_a = 1'b1;
        repeat (6) tick();
        check("freeze_cnt_pre", u_a.cnt_q, 4);
        en_a = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            check("freeze_q", q_a, 0);
        end
        check("freeze_cnt", u_a.cnt_q, 4);
        check("freeze_busy", busy_a, 1);
        en_a = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("resume_q", q_a, k >= 4);
`ifdef DEBOUNCE_FILTER_EDGE_OUT_EN
            check("resume_rise", rise_a, k == 4);
`endif
        end
        d_a = 1'b0;
        repeat (12) tick();
        check("settle_q", q_a, 0);
        // async reset mid-count
        d_a = 1'b1;
        repeat (7) tick();
        check("pre_rst_busy", busy_a, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_q", q_a, 0);
        check("async_busy", busy_a, 0);
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            tick();
            check("post_rst_q", q_a, k >= 10);
        end
        // DebounceCount=1, SyncStages=3: q is d delayed by 4 clocks
        for (int k = 1; k <= 28; k++) begin
            d_c = (((k - 1) / 4) % 2) == 0;
            hist[k] = d_c;
            tick();
            check("min_q", q_c, (k >= 4) ? hist[k-3] : 1'b0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
